// File: rtl/idct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer: rows are written into one bank while the
// other bank is read out column by column.
module idct_transpose_buffer #(
  parameter int unsigned ELEM_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*ELEM_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*ELEM_W-1:0] out_data,
  output logic                out_last
);

  localparam int unsigned VecW = 8 * ELEM_W;

  logic [VecW-1:0] mem_q [2][8];

  logic       wr_bank_q, wr_bank_d;
  logic [2:0] wr_row_q, wr_row_d;
  logic       rd_bank_q, rd_bank_d;
  logic [2:0] rd_col_q, rd_col_d;
  logic [1:0] full_q, full_d;
  logic       wr_en, rd_en;

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_last  = out_valid && (rd_col_q == 3'd7);
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = out_valid && out_ready;

  // Writes need full=0 and reads need full=1, so the two sides never touch
  // the same full bit in one cycle.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    rd_bank_d = rd_bank_q;
    rd_col_d  = rd_col_q;
    full_d    = full_q;
    if (wr_en) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_row_q == 3'd7) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
    if (rd_en) begin
      rd_col_d = rd_col_q + 3'd1;
      if (rd_col_q == 3'd7) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      wr_row_q  <= 3'd0;
      rd_bank_q <= 1'b0;
      rd_col_q  <= 3'd0;
      full_q    <= 2'b00;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      rd_bank_q <= rd_bank_d;
      rd_col_q  <= rd_col_d;
      full_q    <= full_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by full_q.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_bank_q][wr_row_q] <= in_data;
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned r = 0; r < 8; r++) begin
      out_data[r*ELEM_W +: ELEM_W] = mem_q[rd_bank_q][r][rd_col_q*ELEM_W +: ELEM_W];
    end
  end

endmodule

// File: tb/tb_idct_transpose_buffer.sv
// Directed and table-driven bench for idct_transpose_buffer, with a queue of
// expected columns built from the rows actually accepted.
module tb_idct_transpose_buffer;

  localparam int unsigned W  = 32;
  localparam int unsigned VW = 8 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, out_last;
  logic [VW-1:0] in_data, out_data;
  logic          in_valid16, in_ready16, out_valid16, out_ready16, out_last16;
  logic [127:0]  in_data16, out_data16;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [VW-1:0] data;
    logic          last;
  } col_t;

  typedef struct {
    logic          iv;
    logic [VW-1:0] id;
    logic          ordy;
    logic          e_ir;
    logic          e_ov;
    logic          e_ol;
    logic          chk_d;
    logic [VW-1:0] e_od;
  } vec_t;

  col_t          expq[$];
  logic [VW-1:0] rows[8];
  int            rcnt  = 0;
  int            ncols = 0;
  vec_t          tbl[17];

  idct_transpose_buffer #(.ELEM_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  idct_transpose_buffer #(.ELEM_W(16)) dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid16),
    .in_ready (in_ready16),
    .in_data  (in_data16),
    .out_valid(out_valid16),
    .out_ready(out_ready16),
    .out_data (out_data16),
    .out_last (out_last16)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] row_val(int b, int r);
    logic [VW-1:0] v;
    for (int c = 0; c < 8; c++) v[c*W +: W] = 32'(256 * b + 16 * r + c);
    return v;
  endfunction

  function automatic logic [VW-1:0] col_val(int b, int c);
    logic [VW-1:0] v;
    for (int r = 0; r < 8; r++) v[r*W +: W] = 32'(256 * b + 16 * r + c);
    return v;
  endfunction

  function automatic logic [15:0] e16(int c);
    return (c % 2 == 1) ? 16'hFFFF : 16'h7FFF;
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Score the handshakes that happen at the coming edge, then advance to edge+1.
  task automatic step();
    col_t e;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_col: got column %h want no column", out_data);
      end else begin
        e = expq.pop_front();
        chk("col_data", out_data, e.data);
        chk("col_last", VW'(out_last), VW'(e.last));
      end
      ncols++;
    end
    if (in_valid && in_ready) begin
      rows[rcnt] = in_data;
      rcnt++;
      if (rcnt == 8) begin
        for (int c = 0; c < 8; c++) begin
          e.data = '0;
          for (int r = 0; r < 8; r++) e.data[r*W +: W] = rows[r][c*W +: W];
          e.last = (c == 7);
          expq.push_back(e);
        end
        rcnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [VW-1:0]  held;
    logic [127:0]   v16;
    int             n0;
    int             sent;
    int             cyc;

    for (int i = 0; i < 17; i++) begin
      tbl[i].iv    = (i < 8);
      tbl[i].id    = (i < 8) ? row_val(0, i) : '0;
      tbl[i].ordy  = 1'b1;
      tbl[i].e_ir  = 1'b1;
      tbl[i].e_ov  = (i >= 8 && i < 16);
      tbl[i].e_ol  = (i == 15);
      tbl[i].chk_d = (i >= 8 && i < 16);
      tbl[i].e_od  = (i >= 8 && i < 16) ? col_val(0, i - 8) : '0;
    end

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid16 = 1'b0; in_data16 = '0; out_ready16 = 1'b0;
    #12;
    chk("rst_in_ready", VW'(in_ready), VW'(1));
    chk("rst_out_valid", VW'(out_valid), VW'(0));
    chk("rst_out_last", VW'(out_last), VW'(0));
    chk("rst_in_ready16", VW'(in_ready16), VW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single block, table driven.
    for (int i = 0; i < 17; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].id;
      out_ready = tbl[i].ordy;
      chk("sb_in_ready", VW'(in_ready), VW'(tbl[i].e_ir));
      chk("sb_out_valid", VW'(out_valid), VW'(tbl[i].e_ov));
      chk("sb_out_last", VW'(out_last), VW'(tbl[i].e_ol));
      if (tbl[i].chk_d) chk("sb_out_data", out_data, tbl[i].e_od);
      step();
    end

    // Back-to-back streaming of 4 blocks.
    n0 = ncols;
    for (int i = 0; i < 40; i++) begin
      in_valid  = (i < 32);
      in_data   = row_val(i / 8, i % 8);
      out_ready = 1'b1;
      if (i < 32) chk("st_in_ready", VW'(in_ready), VW'(1));
      chk("st_out_valid", VW'(out_valid), VW'(i >= 8));
      if (i >= 8) chk("st_hand_data", out_data, col_val((i - 8) / 8, (i - 8) % 8));
      step();
    end
    in_valid = 1'b0;
    chk("st_ncols", VW'(ncols - n0), VW'(32));
    chk("st_idle", VW'(out_valid), VW'(0));

    // Backpressure: two blocks fill both banks, 17th row refused.
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = row_val(4 + i / 8, i % 8);
      chk("bp_in_ready", VW'(in_ready), VW'(i < 16));
      step();
    end
    in_valid = 1'b0;
    held = out_data;
    chk("bp_first_col", held, col_val(4, 0));
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_hold_data", out_data, held);
      chk("bp_hold_last", VW'(out_last), VW'(0));
      chk("bp_hold_valid", VW'(out_valid), VW'(1));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("bp_drain_in_ready", VW'(in_ready), VW'(0));
      step();
    end
    chk("bp_in_ready_back", VW'(in_ready), VW'(1));
    for (int k = 0; k < 8; k++) step();
    chk("bp_done_valid", VW'(out_valid), VW'(0));
    chk("bp_q_empty", VW'(expq.size()), VW'(0));

    // Random handshakes over 20 blocks.
    n0 = ncols;
    sent = 0;
    cyc = 0;
    while ((ncols - n0 < 160) && cyc < 6000) begin
      in_valid  = (sent < 160) && ($urandom_range(1) == 1);
      out_ready = ($urandom_range(1) == 1);
      for (int k = 0; k < 8; k++) in_data[k*W +: W] = $urandom();
      if (in_valid && in_ready) sent++;
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rnd_ncols", VW'(ncols - n0), VW'(160));
    chk("rnd_q_empty", VW'(expq.size()), VW'(0));

    // Reset with one block draining (3 columns out) and 5 rows of the next.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = row_val(7, i);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      in_data   = row_val(8, i);
      out_ready = (i < 3);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("mr_pre_valid", VW'(out_valid), VW'(1));
    chk("mr_pre_data", out_data, col_val(7, 3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_in_ready", VW'(in_ready), VW'(1));
    chk("mr_out_valid", VW'(out_valid), VW'(0));
    chk("mr_out_last", VW'(out_last), VW'(0));
    expq.delete();
    rcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = row_val(9, i);
      chk("mr_wr_ready", VW'(in_ready), VW'(1));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("mr_col0", out_data, col_val(9, 0));
    for (int k = 0; k < 8; k++) step();
    chk("mr_done_valid", VW'(out_valid), VW'(0));
    chk("mr_q_empty", VW'(expq.size()), VW'(0));
    out_ready = 1'b0;

    // 16-bit instance: column c is constant, rows alternate.
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) in_data16[c*16 +: 16] = e16(c);
      in_valid16 = 1'b1;
      chk("w16_in_ready", VW'(in_ready16), VW'(1));
      @(posedge clk);
      #1;
    end
    in_valid16  = 1'b0;
    out_ready16 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) v16[r*16 +: 16] = e16(c);
      chk("w16_valid", VW'(out_valid16), VW'(1));
      chk("w16_data", VW'(out_data16), VW'(v16));
      chk("w16_last", VW'(out_last16), VW'(c == 7));
      @(posedge clk);
      #1;
    end
    chk("w16_idle", VW'(out_valid16), VW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
